// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings and oversampling constants.
// Used by the receiver and its baud tick generator.
package uart_defs;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_e;

    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
        int d;
        d = clk_freq / (baud * ovs);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/gen_baudios.sv
// Oversample tick generator: counts 0..DIV-1 while enabled, pulses tick on wrap.
// Clear restarts the count from zero so ticks align to a detected edge.
module gen_baudios #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i & ~clr_i & wrap;

endmodule

// File: rtl/recepcion_uart.sv
// 16x oversampled UART receiver with mid-bit sampling and framing-error pulse.
// Define RECEPCION_UART_PARITY_EN to expect an even-parity bit after bit 7.
module recepcion_uart
    import uart_defs::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       done,
    output logic       busy,
    output logic       err_frame
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);

    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        rx_prev_q;
    logic [1:0]  fill_q;
    logic        armed_q;

    uart_state_e state_q;
    logic [3:0]  samp_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [7:0]  dout_q;
    logic        done_q;
    logic        busy_q;
    logic        err_q;

    logic        tick;
    logic        start_det;
    logic        mid;
    logic        par_bad;

    // fill_q keeps armed from trusting the synchroniser's reset value
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            fill_q    <= {fill_q[0], 1'b1};
            if (fill_q[1] && rx_sync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign start_det = (state_q == IDLE) && armed_q && rx_prev_q && !rx_sync_q;
    assign mid       = tick && (samp_q == 4'(MID_SAMPLE));
    assign shift_d   = {rx_sync_q, shift_q[7:1]};

    gen_baudios #(
        .DIV (DIV)
    ) u_gen_baudios (
        .clk_i  (clk_in),
        .rst_ni (reset),
        .en_i   (state_q != IDLE),
        .clr_i  (start_det),
        .tick_o (tick)
    );

`ifdef RECEPCION_UART_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            par_err_q <= 1'b0;
        end else if (state_q == START) begin
            par_err_q <= 1'b0;
        end else if (state_q == PARITY && mid) begin
            par_err_q <= rx_sync_q ^ (^shift_q);
        end
    end

    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (tick) begin
                samp_q <= samp_q + 4'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_det) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        samp_q  <= '0;
                    end
                end
                START: begin
                    if (mid) begin
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift_q <= shift_d;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef RECEPCION_UART_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef RECEPCION_UART_PARITY_EN
                PARITY: begin
                    if (mid) begin
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (mid) begin
                        if (rx_sync_q && !par_bad) begin
                            dout_q  <= shift_q;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err_frame = err_q;

endmodule

// File: tb/tb_recepcion_uart.sv
// Scoreboard bench for recepcion_uart at 16 clocks per bit.
// Define RECEPCION_UART_PARITY_EN to add the parity frames.
module tb_recepcion_uart;

    logic       clk_in;
    logic       reset;
    logic       rx;
    logic [7:0] dout;
    logic       done;
    logic       busy;
    logic       err_frame;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   done_cyc[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
`ifdef RECEPCION_UART_PARITY_EN
    bit   par_flip;
`endif

    recepcion_uart #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .rx        (rx),
        .dout      (dout),
        .done      (done),
        .busy      (busy),
        .err_frame (err_frame)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_in);
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (done && err_frame) begin
                chk("done_err_overlap", 1, 0);
            end
            if (done || err_frame) begin
                if (done) begin
                    done_cyc.push_back(cyc);
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {done, err_frame}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {31'd0, err_frame}, {31'd0, e.is_err});
                    chk("dout", {24'd0, dout}, {24'd0, e.data});
                end
            end
        end
    endtask

    task automatic expect_byte(input bit is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
`ifdef RECEPCION_UART_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    initial begin
        int bc;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        rx       = 1'b1;
`ifdef RECEPCION_UART_PARITY_EN
        par_flip = 1'b0;
`endif
        fork
            monitor();
        join_none
        idle(3);
        @(negedge clk_in);
        chk("rst_dout", {24'd0, dout}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_err", {31'd0, err_frame}, 32'h0);
        @(posedge clk_in);
        #1 reset = 1'b1;
        idle(10);

        expect_byte(1'b0, 8'h33);
        send_frame(8'h33, 1'b1);
        idle(20);

        expect_byte(1'b0, 8'hA5);
        expect_byte(1'b0, 8'h5A);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle(20);
        chk("b2b_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            chk("b2b_spacing", done_cyc[2] - done_cyc[1], 160);
        end

        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (busy) bc++;
        end
        idle(1);
        chk("glitch_busy_len", (bc >= 1 && bc <= 10), 1);
        chk("glitch_no_done", done_cyc.size(), 3);

        expect_byte(1'b1, 8'h5A);
        send_frame(8'hFF, 1'b0);
        idle(40);
        @(negedge clk_in);
        chk("wait_busy_hi", {31'd0, busy}, 32'h1);
        idle(1);
        rx = 1'b1;
        idle(6);
        @(negedge clk_in);
        chk("wait_busy_lo", {31'd0, busy}, 32'h0);
        chk("err_dout_kept", {24'd0, dout}, 32'h5A);
        idle(20);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'(8'h3C >> i));
        end
        reset = 1'b0;
        rx    = 1'b1;
        idle(3);
        @(negedge clk_in);
        chk("midrst_dout", {24'd0, dout}, 32'h0);
        chk("midrst_done", {31'd0, done}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        chk("midrst_err", {31'd0, err_frame}, 32'h0);
        @(posedge clk_in);
        #1 reset = 1'b1;
        idle(10);
        expect_byte(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(20);

`ifdef RECEPCION_UART_PARITY_EN
        expect_byte(1'b0, 8'h33);
        send_frame(8'h33, 1'b1);
        idle(20);
        par_flip = 1'b1;
        expect_byte(1'b1, 8'h33);
        send_frame(8'h33, 1'b1);
        par_flip = 1'b0;
        idle(20);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
